fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
Shares the single write port of the team's 8x8 asynchronous FIFO among NUM_REQ producers in the write_clk domain. Round-robin arbitration with bounded burst ownership, so one producer can keep the port for up to MAX_BURST consecutive words. Backpressure comes from the FIFO's mem_full. Sits directly in front of the FIFO write side; its outputs drive the FIFO's write_en and data_in.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width; must match the FIFO data_in width
MAX_BURST, 4, max consecutive accepted words per grant before forced rotation (1..15)
CNT_W, 16, width of the accepted-word statistics counter

Ports:
write_clk  input  1  FIFO write-domain clock; all state on its rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester write request; level, held until granted
req_data  input  NUM_REQ*DATA_W  packed data; slice i belongs to requester i
mem_full  input  1  FIFO full flag, write domain
grant  output  NUM_REQ  one-hot; requester i's word is consumed this cycle
fifo_write_en  output  1  to FIFO write_en
fifo_data  output  DATA_W  to FIFO data_in
owner  output  3  index of current burst owner (valid when busy=1)
busy  output  1  a burst is in progress
word_count  output  CNT_W  total words accepted since reset

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, word_count=0. grant=0, fifo_write_en=0, fifo_data=0, busy=0. Takes effect immediately, mid-burst included. An in-flight word is neither granted nor written.
- Combinational outputs: grant, fifo_write_en (= |grant), and fifo_data (= req_data slice of granted index, 0 if none). There is zero-cycle latency from acceptance to FIFO write, so mem_full is never overrun.
- A word is accepted when grant[i]=1 at a rising edge. At most one grant bit is ever set.
- No grant is ever issued while mem_full=1. State is frozen: owner, burst_cnt and rr_ptr hold.
- State IDLE:
  - If mem_full=0 and any req: pick the first set req scanning from rr_ptr upward with wrap.
  - Grant it this cycle; owner<=i, burst_cnt<=1, go BURST.
  - If MAX_BURST=1, stay IDLE and set rr_ptr<=i+1 (mod NUM_REQ).
- State BURST:
  - If req[owner]=1 and mem_full=0: grant owner; burst_cnt<=burst_cnt+1.
  - If req[owner]=1 and mem_full=1: hold BURST and stall.
  - If req[owner]=0: release, no grant this cycle; rr_ptr<=owner+1; go IDLE.
  - When the accepted word makes burst_cnt reach MAX_BURST: rr_ptr<=owner+1; go IDLE.
- Wrap-around: rr_ptr and owner+1 are computed mod NUM_REQ. word_count wraps at 2^CNT_W-1 -> 0 and never saturates.
- busy = (state==BURST).
- Requests from non-owners during BURST are ignored; they are never granted while another owner holds the port.
- Simultaneous: if the owner drops req in the same cycle others raise it, the release cycle is idle and arbitration happens the next cycle.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}
  - default NUM_REQ, DATA_W, MAX_BURST
  - function next_rr(ptr, NUM_REQ)
- One sub-module, rr_pick: a combinational rotating priority encoder with inputs req and rr_ptr, outputs valid and index. It is reusable for the read-side scheduler.

Test Plan:
- Single requester: req=4'b0001, data 0x11..0x14 over 4 cycles, mem_full=0 -> grant=0001 for 4 cycles, fifo_data 0x11,0x12,0x13,0x14; then rotation (idle cycle), word_count=4.
- Fairness: req=4'b1111 held, MAX_BURST=4 -> owners 0,1,2,3,0 with 4 words each; never two grant bits set.
- Backpressure: owner 2 mid-burst at burst_cnt=2, mem_full=1 for 3 cycles -> grant=0 and fifo_write_en=0 for 3 cycles, owner=2 held; resumes for the remaining 2 words.
- Early release: owner 1 drops req after 1 word while req[3]=1 -> one idle cycle, then owner=3 (rr_ptr=2 skips the idle requester 2).
- Reset mid-burst: reset low during BURST with owner=1 and word_count=9 -> grant=0, busy=0, word_count=0 asynchronously; after release, arbitration restarts from requester 0.
- Wrap: preload by running 65535 words, then 2 more -> word_count goes 0xFFFF -> 0x0000 -> 0x0001.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and its round-robin helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Round-robin successor of ptr, wrapping at num_req.
    function automatic logic [2:0] next_rr(input logic [2:0] ptr, input int num_req);
        if (int'(ptr) >= num_req - 1) begin
            return 3'd0;
        end
        return ptr + 3'd1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after rr_ptr_i, wrapping at N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   rr_ptr_i,
    output logic         valid_o,
    output logic [2:0]   index_o
);

    always_comb begin
        int cand;
        valid_o = 1'b0;
        index_o = '0;
        cand    = 0;
        // Walk from the farthest offset back so the nearest set request wins.
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int j = 0; j < N; j++) begin
                if (req_i[j] && (j == cand)) begin
                    valid_o = 1'b1;
                    index_o = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = 16
) (
    input  logic                      write_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      mem_full,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [2:0]                owner,
    output logic                      busy,
    output logic [CNT_W-1:0]          word_count
);

    state_e            state_q, state_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        owner_q, owner_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic              pick_valid;
    logic [2:0]        pick_idx;
    logic              req_owner;
    logic              grant_vld;
    logic [2:0]        grant_idx;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .index_o  (pick_idx)
    );

    always_comb begin
        req_owner = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                req_owner = req[i];
            end
        end
    end

    // Handshake: a word moves when grant[i] is high at a rising edge; there is no
    // ready back to the producer other than grant, and mem_full suppresses every grant.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        grant_vld   = 1'b0;
        grant_idx   = '0;
        // Outputs stay quiet while reset is asserted, even before any clock edge.
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (!mem_full && pick_valid) begin
                        grant_vld   = 1'b1;
                        grant_idx   = pick_idx;
                        owner_d     = pick_idx;
                        burst_cnt_d = 4'd1;
                        if (MAX_BURST == 1) begin
                            rr_ptr_d = next_rr(pick_idx, NUM_REQ);
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
                BURST: begin
                    if (!req_owner) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_rr(owner_q, NUM_REQ);
                    end else if (!mem_full) begin
                        grant_vld   = 1'b1;
                        grant_idx   = owner_q;
                        burst_cnt_d = burst_cnt_q + 4'd1;
                        if (burst_cnt_q + 4'd1 == 4'(MAX_BURST)) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_rr(owner_q, NUM_REQ);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        word_count_d = word_count_q + CNT_W'(grant_vld);
    end

    always_comb begin
        grant     = '0;
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (grant_idx == 3'(i))) begin
                grant[i]  = 1'b1;
                fifo_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fifo_write_en = grant_vld;
    assign owner         = owner_q;
    assign busy          = (state_q == BURST);
    assign word_count    = word_count_q;

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            burst_cnt_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with hand-computed expectations.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;

    logic                      write_clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      mem_full;
    logic [NUM_REQ-1:0]        grant;
    logic                      fifo_write_en;
    logic [DATA_W-1:0]         fifo_data;
    logic [2:0]                owner;
    logic                      busy;
    logic [CNT_W-1:0]          word_count;

    int errors = 0;
    int checks = 0;

    fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (4),
        .CNT_W     (CNT_W)
    ) dut (
        .write_clk     (write_clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .mem_full      (mem_full),
        .grant         (grant),
        .fifo_write_en (fifo_write_en),
        .fifo_data     (fifo_data),
        .owner         (owner),
        .busy          (busy),
        .word_count    (word_count)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge write_clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] v);
        req_data[idx*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        logic [3:0] exp_grant;
        int         own;
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = '0;
        mem_full = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_wen", 32'(fifo_write_en), 32'h0);
        check("rst_data", 32'(fifo_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wc", 32'(word_count), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        req = '0;
        cycle();
        cycle();
        reset = 1'b1;

        // Single requester burst of four words.
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_data(0, 8'h11 + 8'(k));
            #1;
            check("single_grant", 32'(grant), 32'h1);
            check("single_data", 32'(fifo_data), 32'h11 + k);
            check("single_wen", 32'(fifo_write_en), 32'h1);
            cycle();
        end
        req = '0;
        #1;
        check("single_idle_grant", 32'(grant), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);
        check("single_wc", 32'(word_count), 32'd4);
        cycle();

        // Fairness from a fresh rr_ptr=0.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            own = b % 4;
            for (int w = 0; w < 4; w++) begin
                #1;
                exp_grant = 4'b0001 << own;
                check("fair_grant", 32'(grant), 32'(exp_grant));
                check("fair_data", 32'(fifo_data), 32'hA0 + own);
                check("fair_onehot", $countones(grant), 32'd1);
                if (w > 0) begin
                    check("fair_owner", 32'(owner), 32'(own));
                    check("fair_busy", 32'(busy), 32'h1);
                end
                cycle();
            end
        end
        req = '0;
        #1;
        check("fair_wc", 32'(word_count), 32'd20);
        check("fair_end_busy", 32'(busy), 32'h0);
        cycle();

        // Backpressure mid-burst, owner 2 (rr_ptr=1 skips idle requester 1).
        req = 4'b0100;
        set_data(2, 8'h31);
        for (int w = 0; w < 2; w++) begin
            #1;
            check("bp_grant", 32'(grant), 32'b0100);
            cycle();
        end
        mem_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("bp_stall_grant", 32'(grant), 32'h0);
            check("bp_stall_wen", 32'(fifo_write_en), 32'h0);
            check("bp_stall_owner", 32'(owner), 32'd2);
            check("bp_stall_busy", 32'(busy), 32'h1);
            cycle();
        end
        mem_full = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            check("bp_resume_grant", 32'(grant), 32'b0100);
            cycle();
        end
        req = '0;
        #1;
        check("bp_end_busy", 32'(busy), 32'h0);
        check("bp_wc", 32'(word_count), 32'd24);
        cycle();

        // Early release of owner 1 while requester 3 waits.
        req = 4'b0010;
        set_data(1, 8'h51);
        #1;
        check("er_first_grant", 32'(grant), 32'b0010);
        cycle();
        req = 4'b1000;
        #1;
        check("er_release_grant", 32'(grant), 32'h0);
        check("er_release_busy", 32'(busy), 32'h1);
        cycle();
        #1;
        check("er_next_grant", 32'(grant), 32'b1000);
        check("er_next_busy", 32'(busy), 32'h0);
        cycle();
        req = '0;
        #1;
        check("er_owner", 32'(owner), 32'd3);
        check("er_busy", 32'(busy), 32'h1);
        check("er_drop_grant", 32'(grant), 32'h0);
        cycle();
        check("er_wc", 32'(word_count), 32'd26);

        // Asynchronous reset in the middle of owner 1's burst.
        req = 4'b0010;
        cycle();
        cycle();
        #1;
        check("mr_pre_owner", 32'(owner), 32'd1);
        check("mr_pre_busy", 32'(busy), 32'h1);
        check("mr_pre_wc", 32'(word_count), 32'd28);
        reset = 1'b0;
        #1;
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_wen", 32'(fifo_write_en), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_wc", 32'(word_count), 32'h0);
        check("mr_owner", 32'(owner), 32'h0);
        cycle();
        check("mr_hold_wc", 32'(word_count), 32'h0);
        reset = 1'b1;
        req   = 4'b1111;
        #1;
        check("mr_restart_grant", 32'(grant), 32'b0001);
        req = '0;
        cycle();
        check("mr_restart_wc", 32'(word_count), 32'h0);

        // Counter wrap: continuous traffic for 65535 words, then two more.
        req = 4'b1111;
        repeat (65535) cycle();
        check("wrap_ffff", 32'(word_count), 32'hFFFF);
        cycle();
        check("wrap_zero", 32'(word_count), 32'h0);
        cycle();
        check("wrap_one", 32'(word_count), 32'h1);
        req = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
